// File: rtl/audio_parallel_to_serial_i2s_if.sv
// Bus between an I2S transmitter and the logic around it: frame clock, parallel words,
// serial data and the per-slot debug view.
interface audio_parallel_to_serial_i2s_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CW         = 4
);
  logic                  lrck;
  logic [DATA_WIDTH-1:0] datl;
  logic [DATA_WIDTH-1:0] datr;
  logic                  out;
  logic [CW-1:0]         temp;
  logic                  temp2;

  // There is no valid/ready handshake: lrck/datl/datr are sampled on every rising bck and
  // must be stable around it; out/temp/temp2 are registered and update on rising bck.
  modport master (output lrck, datl, datr, input out, temp, temp2);
  modport slave  (input lrck, datl, datr, output out, temp, temp2);
endinterface

// File: rtl/audio_parallel_to_serial_i2s.sv
// I2S transmitter slaved to external BCK/LRCK: loads the left or right word on each LRCK
// transition and shifts it out MSB first, one bit per rising BCK.
module audio_parallel_to_serial_i2s #(
  parameter int DATA_WIDTH = 16,
  parameter int CW         = $clog2(DATA_WIDTH)
) (
  input  logic                           bck,
  input  logic                           rst_n,
  audio_parallel_to_serial_i2s_if.slave  bus
);

  logic                  lrck_d;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  out_q;
  logic [CW-1:0]         cnt;
  logic                  slot_start;
  logic [DATA_WIDTH-1:0] word;

  always_comb begin
    slot_start = (bus.lrck != lrck_d);
    word       = bus.lrck ? bus.datr : bus.datl;
  end

  always_ff @(posedge bck) begin
    if (!rst_n) begin
      lrck_d <= 1'b0;
      shreg  <= '0;
      out_q  <= 1'b0;
      cnt    <= '0;
    end else begin
      lrck_d <= bus.lrck;
      if (slot_start) begin
        shreg <= word;
        out_q <= word[DATA_WIDTH-1];
        cnt   <= '0;
      end else begin
        // Zero fill means a slot longer than the word keeps driving 0 after the LSB.
        shreg <= {shreg[DATA_WIDTH-2:0], 1'b0};
        out_q <= shreg[DATA_WIDTH-2];
        if (cnt != CW'(DATA_WIDTH - 1)) begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign bus.out   = out_q;
  assign bus.temp  = cnt;
  assign bus.temp2 = lrck_d;

endmodule

// File: tb/tb_audio_parallel_to_serial_i2s.sv
// Bench for the I2S transmitter: a fixed vector table for reset and the first slot, then
// directed corner sequences and random slots checked against a bit-queue reference model.
module tb_audio_parallel_to_serial_i2s;

  logic bck   = 1'b0;
  logic rst_n = 1'b0;

  always #5 bck = ~bck;

  audio_parallel_to_serial_i2s_if #(.DATA_WIDTH(16), .CW(4)) bus ();

  audio_parallel_to_serial_i2s dut (
    .bck   (bck),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        rst_n;
    logic        lrck;
    logic [15:0] datl;
    logic [15:0] datr;
    logic        exp_out;
    logic [3:0]  exp_temp;
    logic        exp_temp2;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: a slot start queues the word's bits MSB first, every edge pops one
  // (0 once empty); the bit index is simply the edge count since the start, capped at 15.
  logic exp_q[$];
  logic m_out = 1'b0;
  int   m_temp = 0;
  logic m_lr = 1'b0;

  logic [31:0] got_out;
  logic [3:0]  got_temp [32];

  function automatic vec_t mk(input logic r, input logic l, input logic [15:0] dl,
                              input logic [15:0] dr, input logic eo, input int et,
                              input logic e2);
    vec_t v;
    v.rst_n = r; v.lrck = l; v.datl = dl; v.datr = dr;
    v.exp_out = eo; v.exp_temp = 4'(et); v.exp_temp2 = e2;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_edge();
    logic [15:0] w;
    if (!rst_n) begin
      exp_q.delete();
      m_out = 1'b0; m_temp = 0; m_lr = 1'b0;
    end else begin
      if (bus.lrck !== m_lr) begin
        w = bus.lrck ? bus.datr : bus.datl;
        exp_q.delete();
        for (int i = 15; i >= 0; i--) exp_q.push_back(w[i]);
        m_temp = 0;
      end else begin
        m_temp = (m_temp < 15) ? m_temp + 1 : 15;
      end
      m_out = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
      m_lr  = bus.lrck;
    end
  endtask

  // Inputs change on falling bck, like a real I2S master; outputs are read 1 ns after rising bck.
  task automatic drive(input logic r, input logic l, input logic [15:0] dl, input logic [15:0] dr);
    @(negedge bck);
    rst_n = r; bus.lrck = l; bus.datl = dl; bus.datr = dr;
    @(posedge bck);
    model_edge();
    #1;
  endtask

  task automatic step(input logic r, input logic l, input logic [15:0] dl, input logic [15:0] dr);
    drive(r, l, dl, dr);
    check("out", 16'(bus.out), 16'(m_out));
    check("temp", 16'(bus.temp), 16'(m_temp));
    check("temp2", 16'(bus.temp2), 16'(m_lr));
  endtask

  task automatic run_slot(input logic l, input logic [15:0] dl, input logic [15:0] dr, input int len);
    for (int i = 0; i < len; i++) begin
      step(1'b1, l, dl, dr);
      got_out[i]  = bus.out;
      got_temp[i] = bus.temp;
    end
  endtask

  initial begin
    logic [15:0] pat_r;
    logic [15:0] pat_l;
    logic [15:0] rd;
    logic        lr;
    int          len;

    bus.lrck = 1'b0; bus.datl = '0; bus.datr = '0;
    pat_r = 16'b1101010100101010;
    pat_l = 16'b0000111100001111;

    // Reset, idle with lrck low, then a full right slot of 16'hD52A.
    tbl.push_back(mk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 0, 1'b0));
    for (int i = 1; i <= 3; i++)
      tbl.push_back(mk(1'b1, 1'b0, 16'h1234, 16'h0000, 1'b0, i, 1'b0));
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk(1'b1, 1'b1, 16'h0000, 16'hD52A, pat_r[15-i], i, 1'b1));

    foreach (tbl[k]) begin
      drive(tbl[k].rst_n, tbl[k].lrck, tbl[k].datl, tbl[k].datr);
      check("tbl_out", 16'(bus.out), 16'(tbl[k].exp_out));
      check("tbl_temp", 16'(bus.temp), 16'(tbl[k].exp_temp));
      check("tbl_temp2", 16'(bus.temp2), 16'(tbl[k].exp_temp2));
    end

    // Left slot 16'h0F0F.
    run_slot(1'b0, 16'h0F0F, 16'h0000, 16);
    for (int i = 0; i < 16; i++) begin
      check("t3_bit", 16'(got_out[i]), 16'(pat_l[15-i]));
      check("t3_temp", 16'(got_temp[i]), 16'(i));
    end

    // datl changes mid-slot: current word unaffected, next left slot starts with 1.
    run_slot(1'b1, 16'h0000, 16'h3C5A, 16);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, (i < 4) ? 16'h0F0F : 16'h8F0F, 16'h0000);
      got_out[i] = bus.out;
    end
    for (int i = 0; i < 16; i++) check("t4_old_word", 16'(got_out[i]), 16'(pat_l[15-i]));
    run_slot(1'b1, 16'h8F0F, 16'hFFFF, 16);
    run_slot(1'b0, 16'h8F0F, 16'h0000, 16);
    check("t4_next_msb", 16'(got_out[0]), 16'h0001);

    // 20-bck slot: last four bits are 0 and the index sits at 15.
    run_slot(1'b1, 16'h0000, 16'hFFFF, 20);
    for (int i = 16; i < 20; i++) begin
      check("t5_tail_out", 16'(got_out[i]), 16'h0000);
      check("t5_tail_temp", 16'(got_temp[i]), 16'd15);
    end

    // Reset pulse in the middle of a right word, then framing picks up again.
    run_slot(1'b0, 16'hAAAA, 16'h0000, 16);
    run_slot(1'b1, 16'h0000, 16'hFFFF, 6);
    step(1'b0, 1'b1, 16'h0000, 16'hFFFF);
    check("t6_rst_out", 16'(bus.out), 16'h0000);
    check("t6_rst_temp", 16'(bus.temp), 16'h0000);
    run_slot(1'b1, 16'h0000, 16'hFFFF, 10);
    run_slot(1'b0, 16'h9001, 16'h0000, 16);
    check("t6_clean_msb", 16'(got_out[0]), 16'h0001);
    check("t6_clean_lsb", 16'(got_out[15]), 16'h0001);

    // Random slots of varying length (including short, aborted words) and rare resets.
    lr = 1'b1;
    for (int s = 0; s < 40; s++) begin
      len = $urandom_range(24, 3);
      rd  = 16'($urandom);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(99, 0) < 2)
          step(1'b0, lr, rd, ~rd);
        else
          step(1'b1, lr, rd, ~rd);
        if ($urandom_range(3, 0) == 0) rd = 16'($urandom);
      end
      lr = ~lr;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
